// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NUM_RD registered write-first read ports,
// two write ports (B has priority), optional hardwired zero entry and a sequential clear sweep.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       SYS_clk,
   input  logic                       SYS_rst,
   input  logic [NUM_RD*ADDR_W-1:0]   REG_rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   REG_rd_data,
   input  logic                       REG_wr_en_a,
   input  logic [ADDR_W-1:0]          REG_wr_addr_a,
   input  logic [DATA_W-1:0]          REG_wr_data_a,
   input  logic                       REG_wr_en_b,
   input  logic [ADDR_W-1:0]          REG_wr_addr_b,
   input  logic [DATA_W-1:0]          REG_wr_data_b,
   input  logic                       REG_clr_req,
   output logic                       REG_busy,
   output logic                       REG_wr_drop
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic HAS_ZERO = (ZERO_REG != 0);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [ADDR_W-1:0]  sweep_cnt;
   logic               wr_open;
   logic               clr_we;
   logic               acc_a;
   logic               acc_b;
   logic               drop_q;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DATA_W-1:0]  rd_q [NUM_RD];
   logic [DATA_W-1:0]  rd_next [NUM_RD];

   always_ff @(posedge SYS_clk) begin
      if (SYS_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (REG_clr_req) state_next = CLEAR;
         CLEAR:   if (sweep_cnt == LAST_ADDR) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The IDLE->CLEAR edge already refuses writes, so the sweep never races a late write.
   always_comb begin
      REG_busy = 1'b0;
      wr_open  = 1'b0;
      clr_we   = 1'b0;
      case (state)
         IDLE: begin
            wr_open = ~REG_clr_req;
         end
         CLEAR: begin
            REG_busy = 1'b1;
            clr_we   = 1'b1;
         end
         default: begin
            REG_busy = 1'b0;
         end
      endcase
   end

   assign acc_a = wr_open && REG_wr_en_a && !(HAS_ZERO && (REG_wr_addr_a == '0));
   assign acc_b = wr_open && REG_wr_en_b && !(HAS_ZERO && (REG_wr_addr_b == '0));

   always_ff @(posedge SYS_clk) begin
      if (SYS_rst) begin
         sweep_cnt <= '0;
      end else if (state == IDLE) begin
         sweep_cnt <= '0;
      end else begin
         sweep_cnt <= sweep_cnt + 1'b1;
      end
   end

   always_ff @(posedge SYS_clk) begin
      if (SYS_rst) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= ~wr_open & (REG_wr_en_a | REG_wr_en_b);
      end
   end

   assign REG_wr_drop = drop_q;

   // Port B is written last so it wins a same-address collision with port A.
   always_ff @(posedge SYS_clk) begin
      if (SYS_rst) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem[e] <= '0;
         end
      end else if (clr_we) begin
         mem[sweep_cnt] <= '0;
      end else begin
         if (acc_a) mem[REG_wr_addr_a] <= REG_wr_data_a;
         if (acc_b) mem[REG_wr_addr_b] <= REG_wr_data_b;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = REG_rd_addr[p*ADDR_W +: ADDR_W];

      always_comb begin
         rd_next[p] = mem[ra];
         if (acc_a && (REG_wr_addr_a == ra)) rd_next[p] = REG_wr_data_a;
         if (acc_b && (REG_wr_addr_b == ra)) rd_next[p] = REG_wr_data_b;
         if (clr_we && (sweep_cnt == ra))    rd_next[p] = '0;
         if (HAS_ZERO && (ra == '0))         rd_next[p] = '0;
      end

      always_ff @(posedge SYS_clk) begin
         if (SYS_rst) begin
            rd_q[p] <= '0;
         end else begin
            rd_q[p] <= rd_next[p];
         end
      end

      assign REG_rd_data[p*DATA_W +: DATA_W] = rd_q[p];
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp, checked against a plain array model
// that tracks the clear sweep as a simple integer index.
module tb_reg_file_mp;

   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int NRD = 2;
   localparam int DEP = 64;

   logic               SYS_clk = 1'b0;
   logic               SYS_rst;
   logic [NRD*AW-1:0]  REG_rd_addr;
   logic [NRD*DW-1:0]  REG_rd_data;
   logic               REG_wr_en_a;
   logic [AW-1:0]      REG_wr_addr_a;
   logic [DW-1:0]      REG_wr_data_a;
   logic               REG_wr_en_b;
   logic [AW-1:0]      REG_wr_addr_b;
   logic [DW-1:0]      REG_wr_data_b;
   logic               REG_clr_req;
   logic               REG_busy;
   logic               REG_wr_drop;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [DEP];
   logic [DW-1:0] exp_rd [NRD];
   logic          exp_busy;
   logic          exp_drop;
   int            sweep_idx;

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1)) dut (
      .SYS_clk      (SYS_clk),
      .SYS_rst      (SYS_rst),
      .REG_rd_addr  (REG_rd_addr),
      .REG_rd_data  (REG_rd_data),
      .REG_wr_en_a  (REG_wr_en_a),
      .REG_wr_addr_a(REG_wr_addr_a),
      .REG_wr_data_a(REG_wr_data_a),
      .REG_wr_en_b  (REG_wr_en_b),
      .REG_wr_addr_b(REG_wr_addr_b),
      .REG_wr_data_b(REG_wr_data_b),
      .REG_clr_req  (REG_clr_req),
      .REG_busy     (REG_busy),
      .REG_wr_drop  (REG_wr_drop)
   );

   always #5 SYS_clk = ~SYS_clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic setIdleInputs();
      SYS_rst       = 1'b0;
      REG_rd_addr   = '0;
      REG_wr_en_a   = 1'b0;
      REG_wr_addr_a = '0;
      REG_wr_data_a = '0;
      REG_wr_en_b   = 1'b0;
      REG_wr_addr_b = '0;
      REG_wr_data_b = '0;
      REG_clr_req   = 1'b0;
   endtask

   function automatic void setRead(input int port, input int addr);
      REG_rd_addr[port*AW +: AW] = AW'(addr);
   endfunction

   // Advance the model by one edge using the inputs currently applied.
   task automatic modelEdge();
      bit idle;
      bit accept;
      int ra;
      logic [DW-1:0] v;
      if (SYS_rst) begin
         for (int e = 0; e < DEP; e++) ref_mem[e] = '0;
         for (int p = 0; p < NRD; p++) exp_rd[p] = '0;
         exp_busy  = 1'b0;
         exp_drop  = 1'b0;
         sweep_idx = -1;
         return;
      end
      idle   = (sweep_idx < 0);
      accept = idle && !REG_clr_req;
      for (int p = 0; p < NRD; p++) begin
         ra = int'(REG_rd_addr[p*AW +: AW]);
         v  = ref_mem[ra];
         if (accept && REG_wr_en_a && int'(REG_wr_addr_a) == ra) v = REG_wr_data_a;
         if (accept && REG_wr_en_b && int'(REG_wr_addr_b) == ra) v = REG_wr_data_b;
         if (!idle && ra == sweep_idx) v = '0;
         if (ra == 0) v = '0;
         exp_rd[p] = v;
      end
      exp_drop = !accept && (REG_wr_en_a || REG_wr_en_b);
      if (accept) begin
         if (REG_wr_en_a && REG_wr_addr_a != 0) ref_mem[REG_wr_addr_a] = REG_wr_data_a;
         if (REG_wr_en_b && REG_wr_addr_b != 0) ref_mem[REG_wr_addr_b] = REG_wr_data_b;
      end
      if (idle) begin
         if (REG_clr_req) sweep_idx = 0;
      end else begin
         ref_mem[sweep_idx] = '0;
         sweep_idx++;
         if (sweep_idx == DEP) sweep_idx = -1;
      end
      exp_busy = (sweep_idx >= 0);
   endtask

   task automatic applyStimulus(input string tag);
      modelEdge();
      @(posedge SYS_clk);
      #1;
      for (int p = 0; p < NRD; p++) begin
         checkOutput($sformatf("%s_rd%0d", tag, p), 64'(REG_rd_data[p*DW +: DW]), 64'(exp_rd[p]));
      end
      checkOutput({tag, "_busy"}, 64'(REG_busy), 64'(exp_busy));
      checkOutput({tag, "_drop"}, 64'(REG_wr_drop), 64'(exp_drop));
      setIdleInputs();
   endtask

   task automatic writeA(input int addr, input logic [DW-1:0] data);
      REG_wr_en_a   = 1'b1;
      REG_wr_addr_a = AW'(addr);
      REG_wr_data_a = data;
   endtask

   task automatic writeB(input int addr, input logic [DW-1:0] data);
      REG_wr_en_b   = 1'b1;
      REG_wr_addr_b = AW'(addr);
      REG_wr_data_b = data;
   endtask

   initial begin
      int busy_len;
      int guard;
      sweep_idx = -1;
      for (int e = 0; e < DEP; e++) ref_mem[e] = 'x;
      setIdleInputs();
      @(negedge SYS_clk);

      SYS_rst = 1'b1;
      applyStimulus("reset");
      setRead(0, 1); setRead(1, 2);
      applyStimulus("rd_after_reset");

      writeA(10, 12);
      applyStimulus("wr10");
      setRead(0, 10);
      applyStimulus("rd10");
      writeA(5, 7); setRead(1, 5);
      applyStimulus("bypass5");

      writeA(3, 32'hAAAA); writeB(3, 32'h5555); setRead(0, 3); setRead(1, 3);
      applyStimulus("collide3");
      setRead(0, 3);
      applyStimulus("collide3_after");

      writeA(0, 32'hFFFF); setRead(0, 0);
      applyStimulus("zero_wr");
      setRead(1, 0);
      applyStimulus("zero_rd");

      for (int e = 0; e < DEP; e += 2) begin
         writeA(e, DW'(e)); writeB(e + 1, DW'(e + 1));
         applyStimulus("fill");
      end
      setRead(0, 40); setRead(1, 63);
      applyStimulus("fill_rd");

      REG_clr_req = 1'b1;
      applyStimulus("clr_start");
      busy_len = 0;
      guard = 0;
      while (REG_busy && guard < 100) begin
         busy_len++;
         guard++;
         if (busy_len == 10) writeA(12, 32'hBEEF);
         setRead(0, (busy_len + 5) % DEP); setRead(1, busy_len % DEP);
         REG_clr_req = 1'b1;
         applyStimulus("sweep");
      end
      checkOutput("busy_len", 64'(busy_len), 64'(DEP));
      for (int e = 0; e < DEP; e += 2) begin
         setRead(0, e); setRead(1, e + 1);
         applyStimulus("post_clr_rd");
      end

      for (int e = 1; e < DEP; e++) begin
         writeA(e, DW'(e * 3));
         applyStimulus("refill");
      end
      REG_clr_req = 1'b1;
      applyStimulus("clr2_start");
      for (int c = 1; c < 20; c++) applyStimulus("sweep2");
      SYS_rst = 1'b1;
      applyStimulus("mid_rst");
      for (int e = 0; e < DEP; e += 2) begin
         setRead(0, e); setRead(1, e + 1);
         applyStimulus("post_rst_rd");
      end
      writeA(40, 9);
      applyStimulus("wr40");
      setRead(0, 40);
      applyStimulus("rd40");

      for (int n = 0; n < 600; n++) begin
         for (int p = 0; p < NRD; p++) begin
            setRead(p, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEP - 1));
         end
         if ($urandom_range(0, 2) != 0) writeA($urandom_range(0, 7), $urandom);
         if ($urandom_range(0, 2) != 0) writeB($urandom_range(0, 7), $urandom);
         REG_clr_req = ($urandom_range(0, 59) == 0);
         SYS_rst     = ($urandom_range(0, 199) == 0);
         applyStimulus("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file; next generation of the 64-entry, 2-read, 1-write REG block.
- Generalised data width, depth and read-port count.
- Adds a second write port, registered write-first reads, an optional hardwired zero register, and a sequential clear engine.
- Sits in the decode stage; fed by the instruction decoder (read addresses) and by the writeback and load-return paths (write ports A and B).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- SYS_clk  in  1  system clock; all state changes on its rising edge.
- SYS_rst  in  1  synchronous, active-high reset.
- REG_rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- REG_rd_data  out  NUM_RD*DATA_W  packed registered read data; port i at bits [i*DATA_W +: DATA_W].
- REG_wr_en_a  in  1  write enable, port A (writeback).
- REG_wr_addr_a  in  ADDR_W  write address, port A.
- REG_wr_data_a  in  DATA_W  write data, port A.
- REG_wr_en_b  in  1  write enable, port B (load return).
- REG_wr_addr_b  in  ADDR_W  write address, port B.
- REG_wr_data_b  in  DATA_W  write data, port B.
- REG_clr_req  in  1  start a clear sweep; sampled only in IDLE.
- REG_busy  out  1  high while the clear sweep runs.
- REG_wr_drop  out  1  one-cycle pulse: a write was discarded because the block was busy.

Behaviour:
- Reset (SYS_rst=1 at an edge):
  - All DEPTH entries become 0; REG_rd_data becomes all 0.
  - REG_busy=0, REG_wr_drop=0, state=IDLE, sweep counter=0.
  - Overrides every other input that cycle, including an in-progress sweep (reset mid-sweep ends the sweep).
- States: IDLE and CLEAR.
  - IDLE -> CLEAR when REG_clr_req=1; counter loads 0; REG_busy goes high at that edge.
  - In CLEAR, one entry is zeroed per edge: entry[counter] <= 0, then counter increments.
  - CLEAR -> IDLE on the edge that zeroes entry DEPTH-1; REG_busy goes low at that same edge.
  - A sweep therefore takes exactly DEPTH cycles.
  - REG_clr_req is ignored while in CLEAR.
- Writes, in IDLE only:
  - Port A writes entry[REG_wr_addr_a] when REG_wr_en_a=1; port B likewise.
  - Both ports enabled with the same address: port B wins.
  - With ZERO_REG=1, writes to address 0 are discarded silently (no drop pulse).
- Writes during CLEAR, or on the IDLE->CLEAR edge itself:
  - Discarded.
  - REG_wr_drop=1 on the following cycle if either enable was set; otherwise 0.
- Reads:
  - Latency 1: REG_rd_data[i] at edge k+1 holds entry[REG_rd_addr[i]] as sampled at edge k.
  - Write-first bypass: if an accepted write targets the same address in the same cycle, the new data is returned. When both ports hit that address, port B data is returned.
  - With ZERO_REG=1, address 0 always returns 0.
  - During CLEAR, reads return current array contents; a read of the entry being zeroed that cycle returns 0.
- No other arithmetic; addresses always index in range (DEPTH = 2**ADDR_W).

Test Plan:
- Reset, then read addrs 1,2 -> both ports 0 one cycle later; REG_busy=0.
- Write A addr 10 = 12; next cycle read addr 10 -> 12 after 1 cycle. Write A addr 5 = 7 while reading 5 in the same cycle -> 7 returned (bypass).
- Same cycle: A writes addr 3 = 0xAAAA, B writes addr 3 = 0x5555 -> reads of addr 3 return 0x5555, both in the same cycle (bypass) and afterwards.
- Write addr 0 = 0xFFFF with ZERO_REG=1 -> addr 0 reads 0, REG_wr_drop stays 0.
- Fill entries 0..63 with their index, pulse REG_clr_req:
  - REG_busy high for exactly 64 cycles; all reads then 0.
  - A write in sweep cycle 10 -> REG_wr_drop pulses once and the entry stays 0.
- Assert SYS_rst at sweep cycle 20 -> next cycle REG_busy=0, state IDLE, all entries 0; a subsequent write to addr 40 = 9 reads back 9.
